adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_pkg.sv | 11 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/adc_capture.sv | 140 ++++++++++++++
 tb/tb_adc_capture.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and sample type for the J2 ADC capture path.
package adc_pkg;

    localparam int ADC_W          = 8;
    localparam int CLK_DIV_DEF    = 2;
    localparam int PIPE_DLY_DEF   = 3;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic [ADC_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is taken only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; contents are only visible through non-empty reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adc_capture.sv
// ADC sample clock generation, pipeline-latency discard and FIFO buffering.
// Optional 4-sample averaging is built when ADC_CAPTURE_AVG_EN is defined.
module adc_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int PIPE_DLY   = PIPE_DLY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_en,
    input  logic    i_clr,
    output logic    o_ad_clk,
    input  sample_t i_ad_port,
    output sample_t o_data,
    output logic    o_valid,
    input  logic    i_ready,
    output logic    o_overflow
);

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);
    localparam logic [7:0] DISC_N = 8'(PIPE_DLY);

    logic [7:0] div_q, div_d;
    logic       ad_clk_q, ad_clk_d;
    logic [7:0] disc_q, disc_d;
    logic       ovf_q, ovf_d;
    logic       rise, accept;
    logic       push;
    sample_t    push_data;
    sample_t    fifo_rdata;
    logic       fifo_full, fifo_empty;

    always_comb begin
        div_d    = div_q;
        ad_clk_d = ad_clk_q;
        disc_d   = disc_q;
        rise     = 1'b0;
        accept   = 1'b0;
        if (!i_en) begin
            div_d    = '0;
            ad_clk_d = 1'b0;
            disc_d   = '0;
        end else if (div_q == DIV_TC) begin
            div_d    = '0;
            ad_clk_d = !ad_clk_q;
            rise     = !ad_clk_q;
        end else begin
            div_d = div_q + 8'd1;
        end
        // Samples still inside the ADC pipeline after enable are thrown away.
        if (rise) begin
            if (disc_q == DISC_N) accept = 1'b1;
            else                  disc_d = disc_q + 8'd1;
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    logic [9:0] acc_q, acc_d;
    logic [1:0] ph_q, ph_d;
    logic [9:0] sum;

    assign sum = acc_q + {2'b00, i_ad_port};

    always_comb begin
        acc_d     = acc_q;
        ph_d      = ph_q;
        push      = 1'b0;
        push_data = sum[9:2];
        if (!i_en) begin
            acc_d = '0;
            ph_d  = '0;
        end else if (accept) begin
            if (ph_q == 2'd3) begin
                push  = 1'b1;
                acc_d = '0;
                ph_d  = '0;
            end else begin
                acc_d = sum;
                ph_d  = ph_q + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            ph_q  <= '0;
        end else begin
            acc_q <= acc_d;
            ph_q  <= ph_d;
        end
    end
`else
    assign push      = accept;
    assign push_data = i_ad_port;
`endif

    // A drop clears nothing: it wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr) ovf_d = 1'b0;
        if (push && fifo_full && !i_ready) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q    <= '0;
            ad_clk_q <= 1'b0;
            disc_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            ad_clk_q <= ad_clk_d;
            disc_q   <= disc_d;
            ovf_q    <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (ADC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (o_valid && i_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_ad_clk   = ad_clk_q;
    assign o_valid    = !fifo_empty;
    assign o_data     = fifo_empty ? '0 : fifo_rdata;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: directed phase table, mid-run reset, randomized run
// against a queue-based model of the sample stream.
module tb_adc_capture;

    localparam int CD    = 2;
    localparam int PD    = 3;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [7:0] adc = 8'h00;
    logic       ad_clk, valid, ovf;
    logic [7:0] data;

    int nvec = 0;
    int nerr = 0;

    // model state
    int         m_n = 0;
    logic [7:0] m_q [$];
    bit         m_ovf = 1'b0;
    int         m_sum = 0, m_cnt = 0;

    always #20 clk = ~clk;

    adc_capture #(.CLK_DIV(CD), .PIPE_DLY(PD), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .o_ad_clk   (ad_clk),
        .i_ad_port  (adc),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (rdy),
        .o_overflow (ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_sum = 0;
        m_cnt = 0;
    endtask

    // One i_clk edge with the inputs currently applied.
    task automatic model_step();
        bit         pop, acc, push, drop;
        logic [7:0] pd;
        pop  = (m_q.size() > 0) && rdy;
        acc  = 1'b0;
        push = 1'b0;
        pd   = adc;
        if (en) begin
            m_n++;
            // sample clock rises every 2*CD edges, first after CD edges
            if ((m_n % (2*CD) == CD) && (m_n / (2*CD) >= PD)) acc = 1'b1;
        end else begin
            m_n = 0;
            m_sum = 0;
            m_cnt = 0;
        end
`ifdef ADC_CAPTURE_AVG_EN
        if (acc) begin
            m_sum += int'(adc);
            m_cnt++;
            if (m_cnt == 4) begin
                push  = 1'b1;
                pd    = 8'(m_sum / 4);
                m_sum = 0;
                m_cnt = 0;
            end
        end
`else
        push = acc;
`endif
        drop = push && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(pd);
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic model_check();
        chk("ad_clk", int'(ad_clk), (m_n / CD) % 2);
        chk("valid", int'(valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("data", int'(data), int'(m_q[0]));
        chk("overflow", int'(ovf), int'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic       en, rdy, clr;
        logic [7:0] adc;
        int         ticks;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [$];

    initial begin
        // en rdy clr adc ticks | valid data ovf
        tbl.push_back('{1, 1, 0, 8'hCC, 13, 0, 8'h00, 0}); // discard window
        tbl.push_back('{1, 1, 0, 8'hCC,  1, 1, 8'hCC, 0}); // first kept sample
        tbl.push_back('{1, 1, 0, 8'hCC,  1, 0, 8'h00, 0}); // popped at once
        tbl.push_back('{1, 0, 0, 8'h11, 36, 1, 8'h11, 1}); // 9 pushes, 1 dropped
        tbl.push_back('{0, 1, 0, 8'h11,  8, 0, 8'h00, 1}); // drain 8, flag sticks
        tbl.push_back('{0, 1, 1, 8'h11,  1, 0, 8'h00, 0}); // clear
        tbl.push_back('{1, 0, 0, 8'h5A, 42, 1, 8'h5A, 0}); // refill to full
        tbl.push_back('{1, 0, 0, 8'h5A,  3, 1, 8'h5A, 0});
        tbl.push_back('{1, 1, 0, 8'h77,  1, 1, 8'h5A, 0}); // push+pop when full
        tbl.push_back('{1, 0, 0, 8'h5A,  4, 1, 8'h5A, 1}); // still full -> drop
        tbl.push_back('{0, 1, 1, 8'h5A,  1, 1, 8'h5A, 0});
        tbl.push_back('{0, 1, 0, 8'h5A,  6, 1, 8'h77, 0}); // accepted word last
        tbl.push_back('{0, 1, 0, 8'h5A,  1, 0, 8'h00, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ad_clk", int'(ad_clk), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        model_reset();

`ifndef ADC_CAPTURE_AVG_EN
        foreach (tbl[i]) begin
            en  = tbl[i].en;
            rdy = tbl[i].rdy;
            clr = tbl[i].clr;
            adc = tbl[i].adc;
            repeat (tbl[i].ticks) tick();
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_data", i), int'(data), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].exp_ovf));
        end
        clr = 1'b0;

        // mid-operation reset with 5 stored samples
        en = 1'b0;
        tick();
        en  = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            adc = 8'($urandom);
            tick();
        end
        chk("pre_rst_valid", int'(valid), 1);
        #5 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_ad_clk", int'(ad_clk), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy = 1'b1;
        adc = 8'h3C;
        repeat (13) tick();
        chk("post_rst_discard", int'(valid), 0);
        tick();
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_data", int'(data), 8'h3C);
`else
        en  = 1'b1;
        rdy = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            adc = (i <= 14) ? 8'hCC : (i <= 18) ? 8'hCD : (i <= 22) ? 8'hCE : 8'hCF;
            tick();
        end
        chk("avg_valid", int'(valid), 1);
        chk("avg_data", int'(data), 8'hCD);
`endif

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if (i % 200 < 100) rdy = ($urandom_range(0, 9) == 0);
            else               rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            adc = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
